// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch feeding a DEPTH-entry FIFO,
// flushed and restarted by redirect. Define PREFETCH_PERF_EN to add the stall_count output.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] queue_count
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]            stall_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic          discard_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];

    logic          push_s;
    logic          pop_s;
    logic [31:0]   target_pc_s;
    logic [31:0]   next_pc_s;

    // A late ack while IDLE belongs to an abandoned request and is ignored.
    assign push_s      = mem_ack & (state_q == ST_REQ) & ~discard_q & ~redirect;
    assign pop_s       = (count_q != {CW{1'b0}}) & instr_ready & ~redirect;
    assign target_pc_s = redirect_pc & 32'hFFFF_FFFC;

    // Address of the following request once the current one is acked.
    always_comb begin
        next_pc_s = fetch_pc_q + 32'd4;
        if (redirect) begin
            next_pc_s = target_pc_s;
        end else if (discard_q) begin
            next_pc_s = fetch_pc_q;
        end else begin
            next_pc_s = fetch_pc_q + 32'd4;
        end
    end

    // Queue pointer and occupancy update; redirect empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Next head word; the word being pushed bypasses storage when it becomes the head.
    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (count_d != {CW{1'b0}}) begin
            if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                instr_d    = mem_rdata;
                instr_pc_d = mem_addr_q;
            end else begin
                instr_d    = fifo_instr_q[rd_ptr_d];
                instr_pc_d = fifo_pc_q[rd_ptr_d];
            end
        end else begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
        end
    end

    // FIFO storage, written at the tail on every accepted return.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_instr_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
        end
    end

    // Queue state and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Fetch FSM: space is judged on next-cycle occupancy, so the in-flight word is always covered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc_s;
                    end
                    if (count_d < DEPTH_C) begin
                        state_q    <= ST_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= redirect ? target_pc_s : fetch_pc_q;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        discard_q  <= 1'b0;
                        fetch_pc_q <= next_pc_s;
                        if (count_d < DEPTH_C) begin
                            mem_addr_q <= next_pc_s;
                        end else begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        fetch_pc_q <= target_pc_s;
                        discard_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count_q != {CW{1'b0}});
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign queue_count = count_q;

`ifdef PREFETCH_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where the consumer waits on an empty queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'h0000_0000;
        end else if (instr_ready && (count_q == {CW{1'b0}}) && !redirect &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed scenarios push expected PCs, a monitor
// pops and compares on every accepted head word.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0000_0000;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  queue_count;
`ifdef PREFETCH_PERF_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int wait_cnt = 0;
    int ack_cnt = 0;
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] req_log [$];
    int          pop_cyc [$];

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .queue_count(queue_count)
`ifdef PREFETCH_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory: word at address a is a ^ DEAD_0000; ack in the mem_lat-th cycle of each request.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 32'hDEAD_0000;
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: logs request starts and checks every accepted head word against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst) begin
            if (mem_req && (!req_prev || ack_prev)) req_log.push_back(mem_addr);
            if (mem_req && mem_ack) ack_cnt++;
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h, expected no word", instr_pc);
                end else begin
                    e = exp_pc_q.pop_front();
                    check32("pop_pc", instr_pc, e);
                    check32("pop_instr", instr, e ^ 32'hDEAD_0000);
                    pop_cyc.push_back(cyc);
                end
            end
            req_prev = mem_req;
            ack_prev = mem_ack;
        end else begin
            req_prev = 1'b0;
            ack_prev = 1'b0;
        end
    end

    task automatic do_reset(input logic rdy);
        rst         = 1'b1;
        instr_ready = rdy;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        repeat (2) @(negedge clk);
        exp_pc_q.delete();
        req_log.delete();
        pop_cyc.delete();
        ack_cnt = 0;
        rst     = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        instr_ready = 1'b1;
        while (exp_pc_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_pc_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words still outstanding, expected 0", name, exp_pc_q.size());
        end
        instr_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_mem_req", mem_req, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0000_0000);
        check32("rst_valid", instr_valid, 32'd0);
        check32("rst_instr", instr, 32'h0000_0000);
        check32("rst_instr_pc", instr_pc, 32'h0000_0000);
        check32("rst_count", queue_count, 32'd0);

        // Back-to-back streaming with single-cycle memory.
        mem_lat = 1;
        do_reset(1'b1);
        #1 check32("t1_req_at_release", mem_req, 32'd0);
        @(negedge clk); #1;
        check32("t1_req_after_edge", mem_req, 32'd1);
        check32("t1_first_addr", mem_addr, 32'h0000_0000);
        exp_pc_q.push_back(32'h0000_0000); exp_pc_q.push_back(32'h0000_0004);
        exp_pc_q.push_back(32'h0000_0008); exp_pc_q.push_back(32'h0000_000C);
        drain("t1");
        check32("t1_req_count", (req_log.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (req_log.size() >= 4) begin
            check32("t1_addr0", req_log[0], 32'h0000_0000);
            check32("t1_addr1", req_log[1], 32'h0000_0004);
            check32("t1_addr2", req_log[2], 32'h0000_0008);
            check32("t1_addr3", req_log[3], 32'h0000_000C);
        end
        if (pop_cyc.size() >= 4) check32("t1_back_to_back", pop_cyc[3] - pop_cyc[0], 32'd3);

        // Consumer stalled: fill to DEPTH, stop requesting, then drain and resume.
        do_reset(1'b0);
        repeat (20) @(negedge clk);
        #1;
        check32("t2_ack_count", ack_cnt, 32'd4);
        check32("t2_count_full", queue_count, 32'd4);
        check32("t2_req_low", mem_req, 32'd0);
        check32("t2_valid", instr_valid, 32'd1);
        check32("t2_head_pc", instr_pc, 32'h0000_0000);
        @(negedge clk);
        exp_pc_q.push_back(32'h0000_0000); exp_pc_q.push_back(32'h0000_0004);
        exp_pc_q.push_back(32'h0000_0008); exp_pc_q.push_back(32'h0000_000C);
        exp_pc_q.push_back(32'h0000_0010); exp_pc_q.push_back(32'h0000_0014);
        drain("t2");
        if (req_log.size() >= 5) check32("t2_resume_addr", req_log[4], 32'h0000_0010);
        else check32("t2_resume_logged", req_log.size(), 32'd5);

        // Redirect while the request for 8 is pending: its word must be dropped.
        mem_lat = 3;
        do_reset(1'b1);
        exp_pc_q.push_back(32'h0000_0000); exp_pc_q.push_back(32'h0000_0004);
        exp_pc_q.push_back(32'h0000_0100); exp_pc_q.push_back(32'h0000_0104);
        n = 0;
        while (!(mem_req && mem_addr == 32'h0000_0008 && !instr_valid) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check32("t3_reach_pending8", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        drain("t3");
        if (req_log.size() >= 4) check32("t3_restart_addr", req_log[3], 32'h0000_0100);
        else check32("t3_restart_logged", req_log.size(), 32'd4);

        // Redirect coinciding with an ack and a pop.
        mem_lat = 1;
        do_reset(1'b1);
        exp_pc_q.push_back(32'h0000_0000); exp_pc_q.push_back(32'h0000_0004);
        exp_pc_q.push_back(32'h0000_0008);
        n = 0;
        while (exp_pc_q.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        check32("t4_reach_steady", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check32("t4_ack_coincide", mem_ack, 32'd1);
        check32("t4_valid_coincide", instr_valid, 32'd1);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check32("t4_count_flushed", queue_count, 32'd0);
        check32("t4_valid_flushed", instr_valid, 32'd0);
        check32("t4_pc_held", instr_pc, 32'h0000_000C);
        check32("t4_req", mem_req, 32'd1);
        check32("t4_restart_addr", mem_addr, 32'h0000_0200);
        exp_pc_q.push_back(32'h0000_0200); exp_pc_q.push_back(32'h0000_0204);
        drain("t4");

        // Asynchronous reset mid-request with data queued.
        mem_lat = 3;
        do_reset(1'b0);
        n = 0;
        while (!(queue_count == 3'd2 && mem_req) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check32("t5_reach_queued", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1;
        check32("t5_async_req", mem_req, 32'd0);
        check32("t5_async_valid", instr_valid, 32'd0);
        check32("t5_async_count", queue_count, 32'd0);
        do_reset(1'b0);
        @(negedge clk); #1;
        check32("t5_req_after", mem_req, 32'd1);
        check32("t5_addr_after", mem_addr, 32'h0000_0000);

`ifdef PREFETCH_PERF_EN
        // Stall counter with a slow memory and an eager consumer.
        mem_lat = 5;
        do_reset(1'b1);
        exp_pc_q.push_back(32'h0000_0000);
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check32("t6_valid_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        check32("t6_stall_count", stall_count, 32'd6);
        drain("t6");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
